// File: rtl/palette_mapper.sv
// Maps 8-bit pixel indices to 12-bit RGB via an MPU-loaded 256x12 palette or a fixed RRRGGGBB expansion.
// Latency 2 clocks on pixel and sync paths; PALETTE_DEFAULT_INIT_EN builds a post-reset palette fill FSM.
module palette_mapper (
  input  logic        clock,
  input  logic        resetN,
  input  logic [7:0]  pixelIndex,
  input  logic        blankIn,
  input  logic        hSyncIn,
  input  logic        vSyncIn,
  input  logic        regWrite,
  input  logic [1:0]  regSelect,
  input  logic [7:0]  regData,
  output logic [11:0] rgbOut,
  output logic        hSyncOut,
  output logic        vSyncOut,
  output logic        busy
);

  function automatic logic [11:0] expand(input logic [7:0] p);
    return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
  endfunction

  logic [7:0]  writePointer;
  logic        phase;
  logic [3:0]  staging;
  logic        bypass;
  logic        fillActive;
  logic [7:0]  fillAddr;

`ifdef PALETTE_DEFAULT_INIT_EN
  typedef enum logic [1:0] {IDLE, FILL, DONE} initState_t;
  initState_t initState;
  logic [7:0] fillCount;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      initState <= FILL;
      fillCount <= 8'd0;
      busy      <= 1'b1;
    end else begin
      case (initState)
        IDLE: begin
          initState <= FILL;
          fillCount <= 8'd0;
          busy      <= 1'b1;
        end
        FILL: begin
          fillCount <= fillCount + 8'd1;
          if (fillCount == 8'hFF) begin
            initState <= DONE;
            busy      <= 1'b0;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

  assign fillActive = (initState == FILL);
  assign fillAddr   = fillCount;
`else
  assign fillActive = 1'b0;
  assign fillAddr   = 8'd0;
  assign busy       = 1'b0;
`endif

  // MPU writes are dropped outright while the fill owns the RAM write port.
  logic regAccept;
  logic mpuCommit;
  assign regAccept = regWrite & ~fillActive;
  assign mpuCommit = regAccept && (regSelect == 2'd1) && phase;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      writePointer <= 8'd0;
      phase        <= 1'b0;
      staging      <= 4'd0;
      bypass       <= 1'b1;
    end else if (regAccept) begin
      case (regSelect)
        2'd0: begin
          writePointer <= regData;
          phase        <= 1'b0;
        end
        2'd1: begin
          if (!phase) begin
            staging <= regData[3:0];
            phase   <= 1'b1;
          end else begin
            writePointer <= writePointer + 8'd1;
            phase        <= 1'b0;
          end
        end
        2'd2: bypass <= regData[0];
        default: ;
      endcase
    end
  end

  logic        ramWe;
  logic [7:0]  ramAddr;
  logic [11:0] ramData;

  always_comb begin
    ramWe   = fillActive | mpuCommit;
    ramAddr = writePointer;
    ramData = {staging, regData};
    if (fillActive) begin
      ramAddr = fillAddr;
      ramData = expand(fillAddr);
    end
  end

  // Simple dual-port RAM; the registered read sees the old word on a same-edge write.
  logic [11:0] palette [256];
  logic [11:0] palRead;

  always_ff @(posedge clock) begin
    if (ramWe) palette[ramAddr] <= ramData;
    palRead <= palette[pixelIndex];
  end

  logic [7:0] s1Index;
  logic       s1Blank;
  logic       s1HSync;
  logic       s1VSync;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      s1Index  <= 8'd0;
      s1Blank  <= 1'b1;
      s1HSync  <= 1'b1;
      s1VSync  <= 1'b1;
      rgbOut   <= 12'h000;
      hSyncOut <= 1'b1;
      vSyncOut <= 1'b1;
    end else begin
      s1Index  <= pixelIndex;
      s1Blank  <= blankIn;
      s1HSync  <= hSyncIn;
      s1VSync  <= vSyncIn;
      hSyncOut <= s1HSync;
      vSyncOut <= s1VSync;
      if (s1Blank)
        rgbOut <= 12'h000;
      else if (bypass || fillActive)
        rgbOut <= expand(s1Index);
      else
        rgbOut <= palRead;
    end
  end

endmodule

// File: tb/tb_palette_mapper.sv
// Self-checking bench for palette_mapper: table vectors, hand sequences and a random run against a reference model.
// The PALETTE_DEFAULT_INIT_EN sections follow the design's build option.
module tb_palette_mapper;

  logic        clock = 1'b0;
  logic        resetN;
  logic [7:0]  pixelIndex;
  logic        blankIn;
  logic        hSyncIn;
  logic        vSyncIn;
  logic        regWrite;
  logic [1:0]  regSelect;
  logic [7:0]  regData;
  logic [11:0] rgbOut;
  logic        hSyncOut;
  logic        vSyncOut;
  logic        busy;

  palette_mapper dut (
    .clock(clock), .resetN(resetN), .pixelIndex(pixelIndex), .blankIn(blankIn),
    .hSyncIn(hSyncIn), .vSyncIn(vSyncIn), .regWrite(regWrite), .regSelect(regSelect),
    .regData(regData), .rgbOut(rgbOut), .hSyncOut(hSyncOut), .vSyncOut(vSyncOut), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [11:0] rgb; logic hs; logic vs; } outRec_t;
  typedef struct { logic [7:0] pix; logic blk; logic hs; logic vs; logic [11:0] rgb; } vec_t;

  // Reference model state: what the MPU has programmed, kept as plain integers/arrays.
  logic [11:0] mPal [256];
  int          mPtr;
  int          mPhase;
  int          mStage;
  int          mBypass;
  outRec_t     expQ [$];

  function automatic logic [11:0] expandRef(input int p);
    int r, g, b;
    r = (p >> 5) & 7;
    g = (p >> 2) & 7;
    b = p & 3;
    return 12'((r * 2 + r / 4) * 256 + (g * 2 + g / 4) * 16 + b * 5);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic modelWrite(input logic [1:0] sel, input logic [7:0] dat);
    case (sel)
      2'd0: begin mPtr = int'(dat); mPhase = 0; end
      2'd1: begin
        if (mPhase == 0) begin
          mStage = int'(dat[3:0]);
          mPhase = 1;
        end else begin
          mPal[mPtr] = {4'(mStage), dat};
          mPtr = (mPtr + 1) % 256;
          mPhase = 0;
        end
      end
      2'd2: mBypass = int'(dat[0]);
      default: ;
    endcase
  endtask

  // One clock: drive inputs, predict this pixel's output, check the pixel from the previous call.
  task automatic cycle(input logic [7:0] pix, input logic blk, input logic hs, input logic vs,
                       input logic we, input logic [1:0] sel, input logic [7:0] dat);
    outRec_t     e;
    outRec_t     g;
    logic [11:0] palVal;
    pixelIndex = pix; blankIn = blk; hSyncIn = hs; vSyncIn = vs;
    regWrite = we; regSelect = sel; regData = dat;
    palVal = mPal[pix];
    if (we) modelWrite(sel, dat);
    e.rgb = blk ? 12'h000 : (mBypass != 0 ? expandRef(int'(pix)) : palVal);
    e.hs = hs;
    e.vs = vs;
    expQ.push_back(e);
    @(posedge clock); #1;
    regWrite = 1'b0;
    if (expQ.size() == 2) begin
      g = expQ.pop_front();
      check("pipe_rgb", 32'(rgbOut), 32'(g.rgb));
      check("pipe_sync", {30'd0, hSyncOut, vSyncOut}, {30'd0, g.hs, g.vs});
    end
  endtask

  task automatic idle();
    cycle(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] dat);
    cycle(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, sel, dat);
  endtask

  task automatic pixel(input logic [7:0] pix);
    cycle(pix, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic modelReset();
    mPtr = 0; mPhase = 0; mStage = 0; mBypass = 1;
`ifdef PALETTE_DEFAULT_INIT_EN
    for (int i = 0; i < 256; i++) mPal[i] = expandRef(i);
`endif
    expQ.delete();
    expQ.push_back('{rgb: 12'h000, hs: 1'b1, vs: 1'b1});
  endtask

  task automatic assertReset();
    @(posedge clock); #2;
    resetN = 1'b0;
    #1;
    check("async_rgb", 32'(rgbOut), 32'h000);
    check("async_sync", {30'd0, hSyncOut, vSyncOut}, 32'd3);
    pixelIndex = 8'h00; blankIn = 1'b1; hSyncIn = 1'b1; vSyncIn = 1'b1; regWrite = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) resetN = 1'b1;
  endtask

  // Clocks until busy drops (bounded); optional reg2 write at edge writeAt; stops early at stopAt.
  task automatic runFill(input int writeAt, input int stopAt, output int n);
    n = 999;
    for (int k = 1; k <= 400; k++) begin
      if (k == writeAt) begin regWrite = 1'b1; regSelect = 2'd2; regData = 8'h00; end
      @(posedge clock); #1;
      regWrite = 1'b0;
      if (k == stopAt || !busy) begin n = k; break; end
    end
  endtask

  task automatic doReset();
    int n;
    assertReset();
    modelReset();
`ifdef PALETTE_DEFAULT_INIT_EN
    check("busy_after_reset", 32'(busy), 32'd1);
    runFill(0, 0, n);
    check("fill_length", 32'(n), 32'd256);
`else
    @(posedge clock); #1;
    check("busy_tied_low", 32'(busy), 32'd0);
`endif
  endtask

  vec_t vecs [6];

  initial begin
    resetN = 1'b1; pixelIndex = 8'h00; blankIn = 1'b1; hSyncIn = 1'b1; vSyncIn = 1'b1;
    regWrite = 1'b0; regSelect = 2'd0; regData = 8'h00;
    for (int i = 0; i < 256; i++) mPal[i] = 12'h000;

    vecs[0] = '{pix: 8'hE0, blk: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 12'hF00};
    vecs[1] = '{pix: 8'h1C, blk: 1'b0, hs: 1'b0, vs: 1'b1, rgb: 12'h0F0};
    vecs[2] = '{pix: 8'h03, blk: 1'b0, hs: 1'b1, vs: 1'b0, rgb: 12'h00F};
    vecs[3] = '{pix: 8'h24, blk: 1'b0, hs: 1'b0, vs: 1'b0, rgb: 12'h220};
    vecs[4] = '{pix: 8'hFF, blk: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 12'hFFF};
    vecs[5] = '{pix: 8'hFF, blk: 1'b1, hs: 1'b0, vs: 1'b1, rgb: 12'h000};

    doReset();

    // Bypass expansion and blanking, compared two clocks after each input.
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) cycle(vecs[i].pix, vecs[i].blk, vecs[i].hs, vecs[i].vs, 1'b0, 2'd0, 8'h00);
      else idle();
      if (i >= 1) begin
        check("tbl_rgb", 32'(rgbOut), 32'(vecs[i-1].rgb));
        check("tbl_sync", {30'd0, hSyncOut, vSyncOut}, {30'd0, vecs[i-1].hs, vecs[i-1].vs});
      end
    end

    // Load every palette entry with random colours while random pixels stream through.
    wr(2'd0, 8'h00);
    for (int i = 0; i < 512; i++)
      cycle(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 2'd1, 8'($urandom));

    // Auto-increment load across the 0xFF -> 0x00 wrap.
    wr(2'd2, 8'h00);
    wr(2'd0, 8'hFE);
    wr(2'd1, 8'h0A); wr(2'd1, 8'h5C);
    wr(2'd1, 8'h01); wr(2'd1, 8'h23);
    wr(2'd1, 8'h04); wr(2'd1, 8'h56);
    pixel(8'hFF); idle();
    check("load_ff", 32'(rgbOut), 32'h123);
    pixel(8'hFE); idle();
    check("load_fe", 32'(rgbOut), 32'hA5C);
    pixel(8'h00); idle();
    check("load_wrap_00", 32'(rgbOut), 32'h456);
    cycle(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00); idle();
    check("blank_palette_mode", 32'(rgbOut), 32'h000);

    // Read/write collision on entry 0x10.
    wr(2'd0, 8'h10); wr(2'd1, 8'h01); wr(2'd1, 8'h11);
    wr(2'd0, 8'h10); wr(2'd1, 8'h09);
    cycle(8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 8'h99);
    pixel(8'h10);
    check("collision_old", 32'(rgbOut), 32'h111);
    idle();
    check("collision_new", 32'(rgbOut), 32'h999);

    // Register 0 write in phase 1 discards the staged red nibble.
    wr(2'd0, 8'h30); wr(2'd1, 8'h07);
    wr(2'd0, 8'h31); wr(2'd1, 8'h02); wr(2'd1, 8'h34);
    pixel(8'h31); idle();
    check("reg0_discards_stage", 32'(rgbOut), 32'h234);

    // Random mix of pixels and back-to-back register traffic, palette mode then bypass mode.
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] sel;
      sel = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3) : 2'd1;
      cycle(8'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 2) == 0), sel, 8'($urandom));
    end
    wr(2'd2, 8'h01);
    for (int i = 0; i < 300; i++)
      cycle(8'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 2) == 0), 2'd1, 8'($urandom));

    // Mid-frame, mid-phase reset: outputs clear asynchronously and the staged nibble is lost.
    cycle(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    cycle(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    cycle(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'h0F);
    check("pre_reset_rgb", 32'(rgbOut), 32'hFFF);
    doReset();
    wr(2'd1, 8'h0B); wr(2'd1, 8'hCD); wr(2'd2, 8'h00);
    pixel(8'h00); idle();
    check("reset_clears_phase", 32'(rgbOut), 32'hBCD);

`ifdef PALETTE_DEFAULT_INIT_EN
    begin
      int n;
      // A reg2 write during the fill is dropped; the fill leaves expand(i) everywhere.
      assertReset();
      modelReset();
      runFill(10, 0, n);
      check("init_busy_len", 32'(n), 32'd256);
      wr(2'd0, 8'h30); wr(2'd1, 8'h0A); wr(2'd1, 8'hBC);
      pixel(8'h30); idle();
      check("init_ctrl_kept", 32'(rgbOut), 32'h290);
      wr(2'd2, 8'h00);
      pixel(8'h24); idle();
      check("init_fill_24", 32'(rgbOut), 32'h220);
      pixel(8'h30); idle();
      check("init_loaded_30", 32'(rgbOut), 32'hABC);

      // Reset at fill counter 100 restarts the full 256-clock fill.
      assertReset();
      runFill(0, 100, n);
      check("midfill_busy", 32'(busy), 32'd1);
      assertReset();
      modelReset();
      runFill(0, 0, n);
      check("midfill_restart_len", 32'(n), 32'd256);
      wr(2'd2, 8'h00);
      pixel(8'hE0); idle();
      check("midfill_fill_e0", 32'(rgbOut), 32'hF00);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
